// File: rtl/div_unit.sv
// Sequential restoring divider (signed/unsigned), result packed as {remainder, quotient}.
// Latency: WIDTH+1 cycles from the accepting edge to ready_o; divide-by-zero answers after 1 cycle.
// Backpressure: result and ready_o are held while start_i stays high; dropping start_i releases the unit.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_r;      // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic             op_accept;
    logic             op_zero;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Operand magnitudes at capture and one restoring shift-subtract step.
    always_comb begin
        op_accept = start_i && !annul_i;
        op_zero   = (opdata2_i == '0);
        mag1      = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2      = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        trial     = {rem_r, quo_r[WIDTH-1]};
        diff      = trial - {1'b0, dvs_r};
        // A borrow out of the trial subtraction means the divisor did not fit: restore.
        rem_step  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_step  = {quo_r[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Next-state selection; annul only matters while a result is still pending.
    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (op_accept) begin
                    state_nxt = op_zero ? BYZERO : ON;
                end
            end
            BYZERO: state_nxt = annul_i ? FREE : END;
            ON: begin
                if (annul_i) begin
                    state_nxt = FREE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // State register, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FREE;
            cnt      <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            dvs_r    <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (op_accept && !op_zero) begin
                        quo_r   <= mag1;
                        rem_r   <= '0;
                        dvs_r   <= mag2;
                        neg_q_r <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r_r <= signed_div_i && opdata1_i[WIDTH-1];
                        cnt     <= '0;
                    end
                end
                BYZERO: begin
                    ready_o  <= !annul_i;
                    result_o <= '0;
                end
                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        cnt      <= '0;
                    end else if (cnt == CNT_LAST) begin
                        ready_o  <= 1'b1;
                        result_o <= {(neg_r_r ? -rem_r : rem_r), (neg_q_r ? -quo_r : quo_r)};
                    end else begin
                        quo_r <= quo_step;
                        rem_r <= rem_step;
                        cnt   <= cnt + CW'(1);
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port signed_div_i, input, 1; 1 selects two's-complement division, 0 selects unsigned.
REQ-005 SHALL have port opdata1_i, input, WIDTH, the dividend.
REQ-006 SHALL have port opdata2_i, input, WIDTH, the divisor.
REQ-007 SHALL have port start_i, input, 1, the request; it is held high until ready_o has been seen.
REQ-008 SHALL have port annul_i, input, 1, which cancels an in-flight division (pipeline flush).
REQ-009 SHALL have port result_o, output, 2*WIDTH, laid out as {remainder, quotient}.
REQ-010 SHALL have port ready_o, output, 1, marking result_o as valid.

Function
REQ-011 SHALL implement states FREE, BYZERO, ON and END, with registered ready_o and result_o.
REQ-012 In FREE with start_i=1, annul_i=0 and opdata2_i!=0, the block SHALL capture the operands and signed_div_i, then go to ON with iteration counter 0; this sampling edge is called edge 0.
REQ-013 In FREE with start_i=1, annul_i=0 and opdata2_i=0, the block SHALL go to BYZERO.
REQ-014 In BYZERO it SHALL go to END at the next edge, with result_o=0 and ready_o=1.
REQ-015 Signed mode: each negative operand SHALL be replaced by its two's-complement magnitude at capture.
REQ-016 ON SHALL perform one restoring shift-subtract step per edge, producing one quotient bit per step, on edges 1..WIDTH.
REQ-017 On edge WIDTH+1 the block SHALL apply sign correction and go to END, with ready_o=1 and result_o valid.
REQ-018 Sign correction: the quotient SHALL be negated when the operand signs differ (signed mode only).
REQ-019 Sign correction: the remainder SHALL be negated when the dividend is negative (signed mode only).
REQ-020 All arithmetic SHALL truncate to WIDTH bits; most-negative / -1 gives quotient = most-negative and remainder = 0.
REQ-021 In END with start_i=1, the block SHALL hold result_o and ready_o unchanged.
REQ-022 In END with start_i=0, the block SHALL go to FREE at the next edge, with ready_o=0 and result_o=0.
REQ-023 annul_i=1 in ON or BYZERO SHALL force FREE at the next edge with ready_o=0 and result_o=0; no result is delivered.
REQ-024 annul_i=1 in END SHALL be ignored; only start_i releases END.
REQ-025 Operand and signed_div_i changes after edge 0 SHALL NOT affect the result in progress.
REQ-026 In FREE, ready_o=0 and result_o=0 SHALL hold; start_i=0 keeps the block in FREE.
REQ-027 A new request SHALL be accepted no earlier than the edge after the return to FREE.
REQ-028 Back-to-back throughput SHALL be one result per WIDTH+3 cycles.

Reset
REQ-029 At any rising edge with rst=0, the block SHALL enter FREE with ready_o=0, result_o=0, counter=0 and internal dividend/divisor registers cleared, whatever state it was in.
REQ-030 Reset SHALL take priority over start_i and annul_i.
REQ-031 A division interrupted by reset SHALL produce no ready_o pulse.

Verification
REQ-032 WIDTH=32, unsigned, 100/7, start held -> ready_o rises at edge 33; result_o={0x00000002, 0x0000000E}; held until start_i drops, then 0 one edge later.
REQ-033 WIDTH=32, signed, -7/2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD} at edge 33.
REQ-034 WIDTH=32, signed, 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000, 0x80000000} at edge 33.
REQ-035 WIDTH=32, divisor 0 -> BYZERO; ready_o=1 at edge 1; result_o=0.
REQ-036 WIDTH=32, 100/7 with annul_i pulsed for one cycle before edge 10 -> FREE at edge 10; ready_o never rises; a following 9/3 returns {0, 3} at edge 33 of the new request.
REQ-037 WIDTH=8, unsigned, 0xFF/0x10 -> result_o={0x0F, 0x0F} at edge 9; separately, rst=0 at edge 5 of a division -> all outputs 0 from edge 5 and no ready_o.
